// File: rtl/vga_dot_display.sv
// 640x480@60Hz VGA renderer that draws up to NUM_DOTS square dots from an
// X/Y position table written through the CPU store path.
module vga_dot_display #(
  parameter int          NUM_DOTS = 450,
  parameter int          DOT_SIZE = 4,
  parameter logic [11:0] DOT_RGB  = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  input  logic        dotWren,
  input  logic        is_Yloc,
  input  logic [31:0] dotID,
  input  logic [31:0] dotLoc
);

  localparam int          IDX_W     = $clog2(NUM_DOTS);
  localparam logic [10:0] DOT_SZ11  = 11'(DOT_SIZE);
  localparam logic [9:0]  H_LAST    = 10'd799;
  localparam logic [9:0]  V_LAST    = 10'd524;
  localparam logic [9:0]  H_VISIBLE = 10'd640;
  localparam logic [9:0]  V_VISIBLE = 10'd480;
  localparam logic [9:0]  HS_START  = 10'd656;
  localparam logic [9:0]  HS_END    = 10'd751;
  localparam logic [9:0]  VS_START  = 10'd490;
  localparam logic [9:0]  VS_END    = 10'd491;

  logic [1:0]  div_q, div_d;
  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic        pixTick;

  logic [9:0]  x_q [NUM_DOTS];
  logic [9:0]  y_q [NUM_DOTS];
  logic        tableWe;
  logic [IDX_W-1:0] wrIdx;

  logic        lit;
  logic        active;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;

  logic        unused_dotLocHigh;

  assign unused_dotLocHigh = ^dotLoc[31:10];
  assign pixTick = (div_q == 2'd3);

  always_comb begin
    div_d  = div_q + 2'd1;
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (pixTick) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = 10'd0;
        vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= 2'd0;
      hCnt_q <= 10'd0;
      vCnt_q <= 10'd0;
    end else begin
      div_q  <= div_d;
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Out-of-range indices are dropped here so only the low index bits address the table.
  assign tableWe = dotWren && (dotID < 32'(NUM_DOTS));
  assign wrIdx   = dotID[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        x_q[i] <= 10'h3FF;
        y_q[i] <= 10'h3FF;
      end
    end else if (tableWe) begin
      if (is_Yloc) begin
        y_q[wrIdx] <= dotLoc[9:0];
      end else begin
        x_q[wrIdx] <= dotLoc[9:0];
      end
    end
  end

  // 11-bit compare keeps X+DOT_SIZE from wrapping for dots parked near 1023.
  always_comb begin
    lit = 1'b0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      if (({1'b0, x_q[i]} <= {1'b0, hCnt_q}) &&
          ({1'b0, hCnt_q} < ({1'b0, x_q[i]} + DOT_SZ11)) &&
          ({1'b0, y_q[i]} <= {1'b0, vCnt_q}) &&
          ({1'b0, vCnt_q} < ({1'b0, y_q[i]} + DOT_SZ11))) begin
        lit = 1'b1;
      end
    end
  end

  always_comb begin
    active = (hCnt_q < H_VISIBLE) && (vCnt_q < V_VISIBLE);
    hs_d   = !((hCnt_q >= HS_START) && (hCnt_q <= HS_END));
    vs_d   = !((vCnt_q >= VS_START) && (vCnt_q <= VS_END));
    rgb_d  = 12'h000;
    if (active) begin
      rgb_d = lit ? DOT_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= 12'h000;
    end else if (pixTick) begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign hSync = hs_q;
  assign vSync = vs_q;
  assign VGA_R = rgb_q[11:8];
  assign VGA_G = rgb_q[7:4];
  assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_dot_display.sv
// Bench for vga_dot_display: a pixel-time reference model plus directed
// placements and random table writes over the first lines of a frame.
module tb_vga_dot_display;

  localparam int NUM_DOTS = 450;
  localparam int DOT_SIZE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        hSync, vSync;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        dotWren = 1'b0;
  logic        is_Yloc = 1'b0;
  logic [31:0] dotID   = 32'd0;
  logic [31:0] dotLoc  = 32'd0;

  int vectors     = 0;
  int miscompares = 0;
  int litCount    = 0;
  bit countLit    = 1'b0;

  int          edgeCnt = 0;
  logic        expHs   = 1'b1;
  logic        expVs   = 1'b1;
  logic [11:0] expRgb  = 12'h000;
  int          mX [NUM_DOTS];
  int          mY [NUM_DOTS];

  vga_dot_display dut (
    .clk     (clk),
    .reset   (reset),
    .hSync   (hSync),
    .vSync   (vSync),
    .VGA_R   (VGA_R),
    .VGA_G   (VGA_G),
    .VGA_B   (VGA_B),
    .dotWren (dotWren),
    .is_Yloc (is_Yloc),
    .dotID   (dotID),
    .dotLoc  (dotLoc)
  );

  always #5 clk = ~clk;

  function automatic bit covers(int h, int v);
    for (int i = 0; i < NUM_DOTS; i++) begin
      if (mX[i] <= h && h < mX[i] + DOT_SIZE && mY[i] <= v && v < mY[i] + DOT_SIZE)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference: after the n-th edge since release, outputs show pixel n/4-1,
  // rendered from the table as it stood before that edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edgeCnt = 0;
      expHs   = 1'b1;
      expVs   = 1'b1;
      expRgb  = 12'h000;
      for (int i = 0; i < NUM_DOTS; i++) begin
        mX[i] = 1023;
        mY[i] = 1023;
      end
    end else begin
      edgeCnt++;
      if (edgeCnt % 4 == 0) begin
        int p, h, v;
        p = edgeCnt / 4 - 1;
        h = p % 800;
        v = (p / 800) % 525;
        expHs  = !(h >= 656 && h <= 751);
        expVs  = !(v >= 490 && v <= 491);
        expRgb = (h < 640 && v < 480 && covers(h, v)) ? 12'hFFF : 12'h000;
      end
      if (dotWren && dotID < NUM_DOTS) begin
        if (is_Yloc) mY[dotID] = int'(dotLoc[9:0]);
        else         mX[dotID] = int'(dotLoc[9:0]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeCnt, got, want);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cycle", {18'd0, hSync, vSync, VGA_R, VGA_G, VGA_B},
                {18'd0, expHs, expVs, expRgb});
    if (countLit && !reset && edgeCnt > 0 && edgeCnt % 4 == 0) begin
      int p;
      p = edgeCnt / 4 - 1;
      if (p % 800 < 640 && p / 800 >= 5 && p / 800 <= 10 && {VGA_R, VGA_G, VGA_B} == 12'hFFF)
        litCount++;
    end
  end

  task automatic applyStimulus(input logic [31:0] id, input bit isY, input logic [9:0] loc,
                               input int holdCycles);
    logic [31:0] junk;
    junk    = $urandom();
    junk[9:0] = loc;
    dotID   = id;
    is_Yloc = isY;
    dotLoc  = junk;
    dotWren = 1'b1;
    repeat (holdCycles) @(negedge clk);
    dotWren = 1'b0;
  endtask

  task automatic waitEdge(input int e);
    int guard;
    guard = 0;
    while (edgeCnt < e) begin
      @(negedge clk);
      guard++;
      if (guard > 100000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL waitEdge: reached edge %0d, required %0d", edgeCnt, e);
        break;
      end
    end
  endtask

  task automatic spotRgb(input int e, input string name, input logic [11:0] want);
    waitEdge(e);
    checkOutput(name, {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, want});
  endtask

  task automatic spotHs(input int e, input string name, input logic want);
    waitEdge(e);
    checkOutput(name, {31'd0, hSync}, {31'd0, want});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time expired at edge %0d", edgeCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {18'd0, hSync, vSync, VGA_R, VGA_G, VGA_B}, 32'h3000);
    #1 reset = 1'b0;

    spotHs(4, "firstTickHs", 1'b1);
    checkOutput("firstTickRgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h0);

    applyStimulus(32'd449, 1'b0, 10'd636, 1);
    applyStimulus(32'd449, 1'b1, 10'd0, 1);
    applyStimulus(32'd450, 1'b0, 10'd0, 1);
    applyStimulus(32'd450, 1'b1, 10'd1, 2);
    applyStimulus(32'hFFFF_FFFF, 1'b1, 10'd0, 1);
    applyStimulus(32'd0, 1'b0, 10'd100, 1);
    applyStimulus(32'd0, 1'b1, 10'd1, 3);
    applyStimulus(32'd1, 1'b0, 10'd10, 1);
    applyStimulus(32'd1, 1'b1, 10'd5, 1);
    applyStimulus(32'd2, 1'b0, 10'd12, 1);
    applyStimulus(32'd2, 1'b1, 10'd7, 1);
    countLit = 1'b1;

    spotRgb(404, "dot0AboveRow", 12'h000);
    spotRgb(2548, "dot449Left", 12'hFFF);
    spotRgb(2560, "dot449Right", 12'hFFF);
    spotRgb(2564, "blankH640", 12'h000);
    spotHs(2627, "hsBeforeFall", 1'b1);
    spotHs(2628, "hsFall", 1'b0);
    spotHs(3011, "hsLastLow", 1'b0);
    spotHs(3012, "hsRise", 1'b1);
    spotRgb(3204, "idx450Ignored", 12'h000);
    spotRgb(3604, "dot0Left", 12'hFFF);
    spotRgb(3616, "dot0Right", 12'hFFF);
    spotRgb(3620, "dot0PastRight", 12'h000);
    spotHs(5827, "hsLine2Before", 1'b1);
    spotHs(5828, "hsLine2Fall", 1'b0);
    spotRgb(6804, "dot0Row2Old", 12'hFFF);

    waitEdge(7600);
    applyStimulus(32'd0, 1'b0, 10'd200, 1);
    spotRgb(10004, "movedOldGone", 12'h000);
    spotRgb(10404, "movedNewLeft", 12'hFFF);
    spotRgb(10416, "movedNewRight", 12'hFFF);
    spotRgb(10420, "movedPastRight", 12'h000);

    spotRgb(16060, "overlapGap", 12'h000);
    spotRgb(22452, "overlapShared", 12'hFFF);
    spotRgb(28856, "overlapDot2Only", 12'hFFF);
    waitEdge(35200);
    countLit = 1'b0;
    checkOutput("overlapUnion", litCount, 32'd28);

    while (edgeCnt < 54400) begin
      if ($urandom_range(0, 7) == 0) begin
        int sel;
        logic [31:0] id;
        bit isY;
        logic [9:0] loc;
        sel = $urandom_range(0, 9);
        case (sel)
          0:       id = $urandom();
          1:       id = 32'(450 + $urandom_range(0, 100));
          2:       id = 32'd449;
          3:       id = 32'($urandom_range(0, 2));
          default: id = 32'($urandom_range(3, 448));
        endcase
        isY = 1'($urandom_range(0, 1));
        loc = isY ? 10'($urandom_range(0, 24)) : 10'($urandom_range(0, 660));
        applyStimulus(id, isY, loc, $urandom_range(1, 3));
      end else begin
        @(negedge clk);
      end
    end

    waitEdge(56000);
    #1 reset = 1'b1;
    #1 checkOutput("midLineReset", {18'd0, hSync, vSync, VGA_R, VGA_G, VGA_B}, 32'h3000);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    spotRgb(2548, "dotsHiddenAfterReset", 12'h000);
    spotHs(2627, "hsBeforeFallAfterReset", 1'b1);
    spotHs(2628, "hsFallAfterReset", 1'b0);
    waitEdge(3300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
